button_event_decoder: RTL and testbench
=======================================

// Module: button_event_decoder
// PURPOSE
//  Consumes the debounced button level and turns it into one-clock event pulses:
//  press, release, single click, double click and long press.
//  Sits between the debouncer and application logic such as counters, LED and
//  menu control. It is the consumer end of the clean-button interface.
//  The input is already clean and synchronous to clk, so it is not re-synchronised here.
// PARAMETERS
//  CLK_HZ      12_000_000  clock frequency, Hz
//  LONG_MS     1000        hold time before long_press fires, ms
//  DOUBLE_MS   300         max gap from release to second press for a double click, ms
//  ACTIVE_HIGH 1           1: btn=1 means pressed; 0: btn=0 means pressed
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  async active-low reset
//  btn            in   1  debounced button level
//  press_pulse    out  1  1-clk pulse on each press edge
//  release_pulse  out  1  1-clk pulse on each release edge
//  single_click   out  1  1-clk pulse: short press, no second press in window
//  double_click   out  1  1-clk pulse: second press inside window
//  long_press     out  1  1-clk pulse: first press held LONG_MS
//  held           out  1  level: button currently pressed (registered)
// BEHAVIOUR
//  - Internal tick constants:
//      LONG_T   = (CLK_HZ/1000)*LONG_MS
//      DBL_T    = (CLK_HZ/1000)*DOUBLE_MS
//  - Counter width is $clog2(max(LONG_T,DBL_T)+1). The counter saturates and never wraps.
//  - p = btn XOR ~ACTIVE_HIGH. p_d is p registered.
//      rise = p & ~p_d
//      fall = ~p & p_d
//  - Reset (async, rst_n=0):
//      all outputs 0, p_d=0, counter 0, state IDLE.
//      If rst_n releases with the button held, this counts as a press
//      (rise on the first edge).
//  - All outputs are registered.
//      Each pulse is high for exactly 1 clk, on the cycle after the edge
//      where rise, fall or timeout is detected.
//  - press_pulse and release_pulse follow rise and fall in every state, independent of the FSM.
//  - held mirrors p_d.
//  - FSM states IDLE, PRESS1, GAP, PRESS2, LONG:
//    IDLE:
//      rise -> PRESS1, cnt=0
//    PRESS1:
//      fall -> GAP, cnt=0
//      else cnt++. When cnt==LONG_T-1: long_press, -> LONG
//    LONG:
//      fall -> IDLE. No click event for this press.
//    GAP:
//      rise -> PRESS2, double_click
//      else cnt++. When cnt==DBL_T-1: single_click, -> IDLE
//    PRESS2:
//      fall -> IDLE
//      No long-press detection in PRESS2.
//  - Simultaneous events: in GAP, a rise on the same cycle as the timeout is a
//    double click (rise has priority). single_click does not fire.
//  - At most one of single_click, double_click and long_press is high in any cycle.
//  - Reset mid-sequence (for example in GAP) discards the pending click.
//    No event is emitted for it.
// TESTING  (CLK_HZ=1000, LONG_MS=10, DOUBLE_MS=5 -> LONG_T=10, DBL_T=5)
//  1. Reset active, btn=0 -> all outputs 0. Release reset -> no pulses, state IDLE.
//  2. Press for 3 clk, release -> press_pulse, then release_pulse.
//     single_click exactly 5 clk after the release edge. No double_click or long_press.
//  3. Press 3 clk, release 2 clk, press 3 clk, release -> one double_click on the
//     second press edge. No single_click. Two press_pulse and two release_pulse.
//  4. Hold 15 clk -> long_press on the 10th held cycle, once.
//     Release -> release_pulse only, no click.
//  5. Press, release, second press exactly when the gap counter hits 4
//     -> double_click only (priority check).
//  6. Press, release, assert rst_n=0 in GAP, then release reset -> no single_click.
//     Next press is decoded normally.
//     With ACTIVE_HIGH=0 and btn inverted, repeat test 2 -> identical pulses.

Source files
------------

// File: rtl/button_event_if.sv
// Clean-button interface: debounced level toward the decoder, event pulses back
// to the application side.
interface button_event_if;
  logic btn;
  logic press_pulse;
  logic release_pulse;
  logic single_click;
  logic double_click;
  logic long_press;
  logic held;

  modport master (
    output btn,
    input  press_pulse,
    input  release_pulse,
    input  single_click,
    input  double_click,
    input  long_press,
    input  held
  );

  modport slave (
    input  btn,
    output press_pulse,
    output release_pulse,
    output single_click,
    output double_click,
    output long_press,
    output held
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a clean, clk-synchronous button level into registered one-clock event pulses:
// press, release, single click, double click and long press.
module button_event_decoder #(
  parameter int unsigned CLK_HZ      = 12_000_000,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned DOUBLE_MS   = 300,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  button_event_if.slave bus
);

  localparam int unsigned LONG_T = (CLK_HZ / 1000) * LONG_MS;
  localparam int unsigned DBL_T  = (CLK_HZ / 1000) * DOUBLE_MS;
  localparam int unsigned MAX_T  = (LONG_T > DBL_T) ? LONG_T : DBL_T;
  localparam int unsigned CW     = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] LongEnd = CW'(LONG_T - 1);
  localparam logic [CW-1:0] DblEnd  = CW'(DBL_T - 1);
  localparam logic [CW-1:0] CntMax  = {CW{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StGap,
    StPress2,
    StLong
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          p, p_q, rise, fall;
  logic          press_q, release_q, single_q, single_d, double_q, double_d, long_q, long_d;

  // Normalise polarity so p=1 always means pressed.
  assign p    = bus.btn ^ ~ACTIVE_HIGH;
  assign rise = p & ~p_q;
  assign fall = ~p & p_q;

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StPress1;
          cnt_d   = '0;
        end
      end
      StPress1: begin
        if (fall) begin
          state_d = StGap;
          cnt_d   = '0;
        end else if (cnt_q == LongEnd) begin
          long_d  = 1'b1;
          state_d = StLong;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StLong: begin
        if (fall) state_d = StIdle;
      end
      StGap: begin
        // A second press on the timeout cycle still counts as a double click.
        if (rise) begin
          double_d = 1'b1;
          state_d  = StPress2;
        end else if (cnt_q == DblEnd) begin
          single_d = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPress2: begin
        if (fall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      p_q       <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p;
      press_q   <= rise;
      release_q <= fall;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.single_click  = single_q;
  assign bus.double_click  = double_q;
  assign bus.long_press    = long_q;
  assign bus.held          = p_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: active-high and active-low instances
// share one pressed level and must produce identical event pulses.
module tb_button_event_decoder;

  localparam logic [4:0] EvP = 5'b10000;
  localparam logic [4:0] EvR = 5'b01000;
  localparam logic [4:0] EvS = 5'b00100;
  localparam logic [4:0] EvD = 5'b00010;
  localparam logic [4:0] EvL = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pressed = 1'b0;
  logic held_exp = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  button_event_if bus_hi ();
  button_event_if bus_lo ();

  assign bus_hi.btn = pressed;
  assign bus_lo.btn = ~pressed;

  button_event_decoder #(
    .CLK_HZ(1000), .LONG_MS(10), .DOUBLE_MS(5), .ACTIVE_HIGH(1'b1)
  ) u_dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_hi)
  );

  button_event_decoder #(
    .CLK_HZ(1000), .LONG_MS(10), .DOUBLE_MS(5), .ACTIVE_HIGH(1'b0)
  ) u_dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    held_exp <= rst_n ? pressed : 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [4:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  // Hold the pressed level for n posedges; called and returns on a negedge.
  task automatic hold(input logic pr, input int n);
    pressed = pr;
    repeat (n) @(negedge clk);
  endtask

  logic [4:0] obs_hi, obs_lo;
  assign obs_hi = {bus_hi.press_pulse, bus_hi.release_pulse, bus_hi.single_click,
                   bus_hi.double_click, bus_hi.long_press};
  assign obs_lo = {bus_lo.press_pulse, bus_lo.release_pulse, bus_lo.single_click,
                   bus_lo.double_click, bus_lo.long_press};

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check_eq("ev_hi", 32'(obs_hi), 32'(e.ev));
      check_eq("ev_lo", 32'(obs_lo), 32'(e.ev));
    end else if (obs_hi != 5'b0 || obs_lo != 5'b0) begin
      check_eq("spurious_hi", 32'(obs_hi), 32'd0);
      check_eq("spurious_lo", 32'(obs_lo), 32'd0);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check_eq("missed", 32'(e.cyc), 32'(cyc));
    end
    check_eq("held_hi", 32'(bus_hi.held), 32'(held_exp));
    check_eq("held_lo", 32'(bus_lo.held), 32'(held_exp));
  end

  int c;

  initial begin
    // Reset with button released
    pressed = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_hi", 32'({obs_hi, bus_hi.held}), 32'd0);
    check_eq("rst_lo", 32'({obs_lo, bus_lo.held}), 32'd0);
    rst_n = 1'b1;
    hold(1'b0, 4);

    // Short press -> single click 5 clk after release
    c = cyc;
    push(c + 1, EvP);
    push(c + 4, EvR);
    push(c + 9, EvS);
    hold(1'b1, 3);
    hold(1'b0, 10);

    // Double click
    c = cyc;
    push(c + 1, EvP);
    push(c + 4, EvR);
    push(c + 6, EvP | EvD);
    push(c + 9, EvR);
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 3);
    hold(1'b0, 10);

    // Long press, release gives no click
    c = cyc;
    push(c + 1, EvP);
    push(c + 11, EvL);
    push(c + 16, EvR);
    hold(1'b1, 15);
    hold(1'b0, 10);

    // Second press on the gap-timeout cycle -> double click only
    c = cyc;
    push(c + 1, EvP);
    push(c + 4, EvR);
    push(c + 9, EvP | EvD);
    push(c + 11, EvR);
    hold(1'b1, 3);
    hold(1'b0, 5);
    hold(1'b1, 2);
    hold(1'b0, 10);

    // Gap timeout one cycle before the second press -> single, then a fresh press
    c = cyc;
    push(c + 1, EvP);
    push(c + 4, EvR);
    push(c + 9, EvS);
    push(c + 10, EvP);
    push(c + 12, EvR);
    push(c + 17, EvS);
    hold(1'b1, 3);
    hold(1'b0, 6);
    hold(1'b1, 2);
    hold(1'b0, 10);

    // Reset in GAP discards the pending click
    c = cyc;
    push(c + 1, EvP);
    push(c + 4, EvR);
    hold(1'b1, 3);
    hold(1'b0, 2);
    rst_n = 1'b0;
    hold(1'b0, 2);
    rst_n = 1'b1;
    hold(1'b0, 10);

    // Next press decodes normally
    c = cyc;
    push(c + 1, EvP);
    push(c + 4, EvR);
    push(c + 9, EvS);
    hold(1'b1, 3);
    hold(1'b0, 10);

    // Reset released with the button held counts as a press
    rst_n = 1'b0;
    hold(1'b1, 2);
    c = cyc;
    rst_n = 1'b1;
    push(c + 1, EvP);
    push(c + 3, EvR);
    push(c + 8, EvS);
    hold(1'b1, 2);
    hold(1'b0, 10);

    check_eq("sb_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
